topk_sort_ctrl: RTL and testbench

Initiator-side sequencer for the top-K sorter: drives its input, sig, asce, is_output and clear_reg pins, and reads the sorted results back.
- Accepts a run of n_elems values over a valid/ready stream from the feature/distance datapath.
- Tags each value with a running index, clears the sorter, inserts every value, then pulls the K sorted entries back.
- Delivers the entries downstream on a valid/ready result port.
- Sits between the distance/score engine and the classifier/vote logic in the accelerator.

---
 rtl/sort_pkg.sv | 10 +
 rtl/topk_sort_ctrl.sv | 147 ++++++++++++++
 tb/tb_topk_sort_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// sort_pkg: sorter command codes, default depth and controller state encoding
package sort_pkg;
    localparam logic [3:0] SIG_NOP  = 4'b0000;
    localparam logic [3:0] SIG_SORT = 4'b0001;
    localparam logic [3:0] SIG_RELU = 4'b0010;
    localparam int K_DEF = 20;
    typedef enum logic [3:0] {
        IDLE, CLEAR, FEED, GAP, DRAIN, READ_REQ, READ_CAP, HOLD, NEXT, DONE
    } state_t;
endpackage

// File: rtl/topk_sort_ctrl.sv
// topk_sort_ctrl: feeds a run of tagged values into the top-K sorter
// and streams the sorted entries back out over a valid/ready port
module topk_sort_ctrl
    import sort_pkg::*;
#(
    parameter int K  = K_DEF,
    parameter int DW = 32,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n_elems,
    input  logic          asce_cfg,
    input  logic [DW-1:0] idx_base,
    input  logic          data_valid,
    input  logic [DW-1:0] data_in,
    output logic          data_ready,
    output logic [DW-1:0] srt_in,
    output logic [DW-1:0] srt_index,
    output logic [3:0]    srt_sig,
    output logic          srt_asce,
    output logic          srt_is_output,
    output logic          srt_clear,
    input  logic [DW-1:0] srt_out,
    input  logic [DW-1:0] srt_out_index,
    output logic          res_valid,
    output logic [DW-1:0] res_value,
    output logic [DW-1:0] res_index,
    output logic [4:0]    res_rank,
    input  logic          res_ready,
    output logic          busy,
    output logic          done
);
    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d, cnt_q, cnt_d;
    logic          asce_q, asce_d, rv_q, rv_d;
    logic [DW-1:0] base_q, base_d, in_q, in_d, idx_q, idx_d;
    logic [DW-1:0] rval_q, rval_d, rind_q, rind_d;
    logic [4:0]    rank_q, rank_d, rrank_q, rrank_d;
    logic          ins;

    assign ins = state_q == FEED && data_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            asce_q  <= 1'b0;
            base_q  <= '0;
            in_q    <= '0;
            idx_q   <= '0;
            rank_q  <= '0;
            rv_q    <= 1'b0;
            rval_q  <= '0;
            rind_q  <= '0;
            rrank_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            asce_q  <= asce_d;
            base_q  <= base_d;
            in_q    <= in_d;
            idx_q   <= idx_d;
            rank_q  <= rank_d;
            rv_q    <= rv_d;
            rval_q  <= rval_d;
            rind_q  <= rind_d;
            rrank_q <= rrank_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        asce_d  = asce_q;
        base_d  = base_q;
        in_d    = in_q;
        idx_d   = idx_q;
        rank_d  = rank_q;
        rv_d    = rv_q;
        rval_d  = rval_q;
        rind_d  = rind_q;
        rrank_d = rrank_q;
        case (state_q)
            IDLE: if (start) begin
                n_d     = n_elems;
                asce_d  = asce_cfg;
                base_d  = idx_base;
                state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = n_q == '0 ? DONE : FEED;
            end
            FEED: if (data_valid) begin
                in_d    = data_in;
                idx_d   = base_q + DW'(cnt_q);
                cnt_d   = cnt_q + 1'b1;
                state_d = GAP;
            end
            GAP: state_d = cnt_q < n_q ? FEED : DRAIN;
            DRAIN: begin
                rank_d  = '0;
                state_d = READ_REQ;
            end
            READ_REQ: state_d = READ_CAP;
            // entries past the run length are stale sorter slots; pull them to keep the pointer aligned
            READ_CAP: if (32'(rank_q) < 32'(n_q)) begin
                rv_d    = 1'b1;
                rval_d  = srt_out;
                rind_d  = srt_out_index;
                rrank_d = rank_q;
                state_d = HOLD;
            end else begin
                state_d = NEXT;
            end
            HOLD: if (res_ready) begin
                rv_d    = 1'b0;
                state_d = NEXT;
            end
            NEXT: begin
                rank_d  = rank_q + 1'b1;
                state_d = rank_q == 5'(K - 1) ? DONE : READ_REQ;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign data_ready    = state_q == FEED;
    assign srt_in        = in_d;
    assign srt_index     = idx_d;
    assign srt_sig       = ins || state_q == READ_REQ || state_q == READ_CAP ? SIG_SORT : SIG_NOP;
    assign srt_asce      = asce_q;
    assign srt_is_output = state_q == READ_REQ;
    assign srt_clear     = state_q == CLEAR;
    assign res_valid     = rv_q;
    assign res_value     = rval_q;
    assign res_index     = rind_q;
    assign res_rank      = rrank_q;
    assign busy          = state_q != IDLE && state_q != DONE;
    assign done          = state_q == DONE;
endmodule

// File: tb/tb_topk_sort_ctrl.sv
// tb_topk_sort_ctrl: drives runs through the controller against a behavioural top-K sorter
// and scores the result stream against independently sorted expectations
module tb_topk_sort_ctrl;
    import sort_pkg::*;
    localparam int K  = 20;
    localparam int DW = 32;
    localparam int NW = 16;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0, asce_cfg = 1'b0;
    logic          data_valid = 1'b0, res_ready = 1'b1;
    logic [NW-1:0] n_elems = '0;
    logic [DW-1:0] idx_base = '0, data_in = '0, srt_out = '0, srt_out_index = '0;
    logic          data_ready, srt_asce, srt_is_output, srt_clear, res_valid, busy, done;
    logic [DW-1:0] srt_in, srt_index, res_value, res_index;
    logic [3:0]    srt_sig;
    logic [4:0]    res_rank;

    typedef struct packed {
        logic [DW-1:0] v;
        logic [DW-1:0] i;
        logic [4:0]    r;
    } res_t;
    res_t exp_q[$];

    int checks = 0, failures = 0;
    int pulses = 0, dones = 0, clears = 0, readys = 0, rvs = 0;
    int stall_cnt = 0, stall_rank = -1, hold_p = 0;
    logic [DW-1:0] hold_v = '0, hold_i = '0;
    logic [DW-1:0] mv[K], mi[K];
    int mcnt = 0, mptr = 0;
    logic [3:0] prev_sig = 4'b0000;
    logic [DW-1:0] d1[$], d25[$], d0[$], d4[$], d5[$];

    topk_sort_ctrl #(.K(K), .DW(DW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .n_elems(n_elems), .asce_cfg(asce_cfg),
        .idx_base(idx_base), .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
        .srt_in(srt_in), .srt_index(srt_index), .srt_sig(srt_sig), .srt_asce(srt_asce),
        .srt_is_output(srt_is_output), .srt_clear(srt_clear), .srt_out(srt_out),
        .srt_out_index(srt_out_index), .res_valid(res_valid), .res_value(res_value),
        .res_index(res_index), .res_rank(res_rank), .res_ready(res_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural sorter: inserts on a rising SORT command, pops one slot per is_output
    always @(posedge clk) begin
        if (!rst || srt_clear) begin
            mcnt = 0;
            mptr = 0;
            for (int j = 0; j < K; j++) begin
                mv[j] = '0;
                mi[j] = '0;
            end
            if (!rst) begin
                srt_out       <= '0;
                srt_out_index <= '0;
            end
        end else if (srt_sig == SIG_SORT && srt_is_output) begin
            srt_out       <= mv[mptr];
            srt_out_index <= mi[mptr];
            mptr = (mptr + 1) % K;
        end else if (srt_sig == SIG_SORT && prev_sig == SIG_NOP) begin
            int p;
            p = mcnt;
            for (int j = mcnt - 1; j >= 0; j--)
                if (srt_asce ? srt_in < mv[j] : srt_in > mv[j]) p = j;
            if (p < K) begin
                for (int j = K - 1; j > p; j--) begin
                    mv[j] = mv[j-1];
                    mi[j] = mi[j-1];
                end
                mv[p] = srt_in;
                mi[p] = srt_index;
                if (mcnt < K) mcnt++;
            end
        end
        prev_sig = rst ? srt_sig : SIG_NOP;
    end

    always @(negedge clk) begin
        res_ready = !(stall_rank >= 0 && stall_cnt < 10 && res_valid && int'(res_rank) == stall_rank);
        if (rst) begin
            pulses += int'(srt_is_output);
            dones  += int'(done);
            clears += int'(srt_clear);
            readys += int'(data_ready);
            rvs    += int'(res_valid);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) check("sb_underflow", 64'(res_value), 64'hdead);
                else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("res_value", 64'(res_value), 64'(e.v));
                    check("res_index", 64'(res_index), 64'(e.i));
                    check("res_rank", 64'(res_rank), 64'(e.r));
                end
            end
            if (res_valid && !res_ready) begin
                if (stall_cnt == 0) begin
                    hold_v = res_value;
                    hold_i = res_index;
                    hold_p = pulses;
                end else begin
                    check("stall_value", 64'(res_value), 64'(hold_v));
                    check("stall_index", 64'(res_index), 64'(hold_i));
                    check("stall_pulses", 64'(pulses), 64'(hold_p));
                end
                stall_cnt++;
            end
        end
    end

    function automatic void push_exp(input int n, input bit asce, input logic [DW-1:0] base,
                                     input logic [DW-1:0] d[$]);
        logic [63:0] pr[$];
        for (int k = 0; k < d.size(); k++) pr.push_back({d[k], base + DW'(k)});
        if (asce) pr.sort();
        else pr.rsort();
        for (int k = 0; k < n && k < K; k++)
            exp_q.push_back('{v: pr[k][63:32], i: pr[k][31:0], r: 5'(k)});
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 64'({data_ready, srt_sig, srt_is_output, srt_clear, srt_asce,
                                  res_valid, busy, done}), 64'h0);
        check({tag, "_srt_in"}, 64'(srt_in), 64'h0);
        check({tag, "_srt_index"}, 64'(srt_index), 64'h0);
        check({tag, "_res"}, {res_value, res_index} | 64'(res_rank), 64'h0);
    endtask

    task automatic run(input int n, input bit asce, input logic [DW-1:0] base,
                       input logic [DW-1:0] d[$], input int stall_at, input bit glitch,
                       input bit done_start);
        int p0, dn0, c0, r0, v0, g, k;
        p0 = pulses; dn0 = dones; c0 = clears; r0 = readys; v0 = rvs;
        stall_rank = stall_at;
        push_exp(n, asce, base, d);
        n_elems = NW'(n); asce_cfg = asce; idx_base = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (glitch) begin
            n_elems = NW'(1);
            asce_cfg = !asce;
        end
        k = 0; g = 0;
        while (k < n && g < 1000) begin
            data_valid = data_ready;
            if (data_ready) begin
                data_in = d[k];
                k++;
            end
            start = glitch && data_valid && k == 2;
            @(posedge clk); #1;
            g++;
        end
        data_valid = 1'b0; start = 1'b0;
        check("feed_in_time", 64'(g < 1000), 64'h1);
        g = 0;
        while (!done && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check("done_seen", 64'(done), 64'h1);
        if (n == 0) check("empty_latency", 64'(g <= 3), 64'h1);
        if (done_start) begin
            start = 1'b1; n_elems = NW'(7);
            @(posedge clk); #1;
            start = 1'b0;
            check("start_in_done", 64'(busy), 64'h0);
        end else begin
            @(posedge clk); #1;
        end
        check("done_pulses", 64'(dones - dn0), 64'h1);
        check("clear_cycles", 64'(clears - c0), 64'h1);
        check("is_output_pulses", 64'(pulses - p0), n > 0 ? 64'(K) : 64'h0);
        check("sb_drained", 64'(exp_q.size()), 64'h0);
        if (n == 0) begin
            check("empty_ready", 64'(readys - r0), 64'h0);
            check("empty_res_valid", 64'(rvs - v0), 64'h0);
        end
        stall_rank = -1;
    endtask

    initial begin
        int k, g, dn0;
        d1 = {32'd7, 32'd3, 32'd9, 32'd1, 32'd5};
        for (int i = 0; i < 25; i++) d25.push_back(DW'(i));
        d4 = {32'd50, 32'd40, 32'd60};
        d5 = {32'd11, 32'd22};
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;
        @(posedge clk); #1;
        run(5, 1'b1, 32'd100, d1, -1, 1'b0, 1'b0);
        run(25, 1'b0, 32'd0, d25, 3, 1'b0, 1'b0);
        check("stall_cycles", 64'(stall_cnt), 64'd10);
        run(0, 1'b1, 32'd0, d0, -1, 1'b0, 1'b0);
        dn0 = dones;
        n_elems = NW'(5); asce_cfg = 1'b1; idx_base = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; g = 0;
        while (k < 4 && g < 100) begin
            data_valid = data_ready;
            if (data_ready) begin
                data_in = d1[k];
                k++;
            end
            @(posedge clk); #1;
            g++;
        end
        data_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("midrun_reset");
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_done_after_reset", 64'(dones - dn0), 64'h0);
        run(5, 1'b1, 32'd100, d1, -1, 1'b0, 1'b0);
        run(3, 1'b1, 32'd7, d4, -1, 1'b1, 1'b1);
        run(2, 1'b0, 32'hFFFF_FFFF, d5, -1, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
